sram_ctrl: RTL

//  Single-port async SRAM access controller (16-bit, 18-bit addr, 256Kx16 part). Converts a

---
 rtl/sram_pkg.sv | 13 +
 rtl/sram_dq_pad.sv | 12 +
 rtl/sram_ctrl.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/sram_pkg.sv
// Shared constants and FSM encoding for the async SRAM access controller.
package sram_pkg;
    localparam int unsigned DEF_ADDR_W = 18;
    localparam int unsigned DEF_DATA_W = 16;
    localparam int unsigned PHASE_W    = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_HOLD   = 2'd3
    } state_t;
endpackage

// File: rtl/sram_dq_pad.sv
// Tristate buffer isolating the bidirectional SRAM data bus from the controller logic.
module sram_dq_pad #(
    parameter int unsigned DATA_W = 16
) (
    input  logic [DATA_W-1:0] wdata,
    input  logic              drive,
    output logic [DATA_W-1:0] rdata,
    inout  wire  [DATA_W-1:0] pad
);
    assign pad   = drive ? wdata : {DATA_W{1'bz}};
    assign rdata = pad;
endmodule

// File: rtl/sram_ctrl.sv
// Async SRAM controller: turns a valid/ready request stream into timed CE/OE/WE/UB/LB/DQ sequences.
// Optional completed-access counters are built when SRAM_CTRL_STATS_EN is defined.
module sram_ctrl
    import sram_pkg::*;
#(
    parameter int unsigned ADDR_W     = DEF_ADDR_W,
    parameter int unsigned DATA_W     = DEF_DATA_W,
    parameter int unsigned SETUP_CYC  = 1,
    parameter int unsigned ACCESS_CYC = 3,
    parameter int unsigned HOLD_CYC   = 1
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_wr,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic [1:0]        req_be,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic [ADDR_W-1:0] SRAM_ADDR,
    inout  wire  [DATA_W-1:0] SRAM_DQ,
    output logic              SRAM_CE,
    output logic              SRAM_OE,
    output logic              SRAM_WE,
    output logic              SRAM_UB,
    output logic              SRAM_LB,
    output logic [31:0]       wr_cnt,
    output logic [31:0]       rd_cnt
);
    localparam int unsigned LANE_W = DATA_W / 2;
    localparam logic [PHASE_W-1:0] SETUP_LD  = PHASE_W'(SETUP_CYC - 1);
    localparam logic [PHASE_W-1:0] ACCESS_LD = PHASE_W'(ACCESS_CYC - 1);
    localparam logic [PHASE_W-1:0] HOLD_LD   = PHASE_W'(HOLD_CYC - 1);

    state_t              state;
    logic [PHASE_W-1:0]  phase;
    logic                ready_q;
    logic                wr_q;
    logic [1:0]          be_q;
    logic [DATA_W-1:0]   wdata_q;
    logic                dq_en;
    logic [DATA_W-1:0]   dq_in;
    logic [DATA_W-1:0]   rd_masked;
    logic                phase_done;

    sram_dq_pad #(.DATA_W(DATA_W)) u_pad (
        .wdata (wdata_q),
        .drive (dq_en),
        .rdata (dq_in),
        .pad   (SRAM_DQ)
    );

    // Lanes whose byte enable was clear read back as zero regardless of the bus.
    assign rd_masked  = {be_q[1] ? dq_in[DATA_W-1:LANE_W] : LANE_W'(0),
                         be_q[0] ? dq_in[LANE_W-1:0]      : LANE_W'(0)};
    assign phase_done = (phase == '0);
    assign req_ready  = ready_q & ~sys_rst;

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state     <= ST_IDLE;
            phase     <= '0;
            ready_q   <= 1'b1;
            wr_q      <= 1'b0;
            be_q      <= '0;
            wdata_q   <= '0;
            dq_en     <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            SRAM_ADDR <= '0;
            SRAM_CE   <= 1'b1;
            SRAM_OE   <= 1'b1;
            SRAM_WE   <= 1'b1;
            SRAM_UB   <= 1'b1;
            SRAM_LB   <= 1'b1;
        end else begin
            rsp_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (req_valid && ready_q) begin
                        wr_q      <= req_wr;
                        be_q      <= req_be;
                        wdata_q   <= req_wdata;
                        SRAM_ADDR <= req_addr;
                        SRAM_CE   <= 1'b0;
                        SRAM_UB   <= ~req_be[1];
                        SRAM_LB   <= ~req_be[0];
                        ready_q   <= 1'b0;
                        phase     <= SETUP_LD;
                        state     <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    if (phase_done) begin
                        SRAM_WE <= ~wr_q;
                        SRAM_OE <= wr_q;
                        dq_en   <= wr_q;
                        phase   <= ACCESS_LD;
                        state   <= ST_ACCESS;
                    end else begin
                        phase <= phase - PHASE_W'(1);
                    end
                end
                ST_ACCESS: begin
                    // Read data is captured on the edge that ends the strobe.
                    if (phase_done) begin
                        SRAM_WE <= 1'b1;
                        SRAM_OE <= 1'b1;
                        if (!wr_q) begin
                            rsp_valid <= 1'b1;
                            rsp_rdata <= rd_masked;
                        end
                        phase <= HOLD_LD;
                        state <= ST_HOLD;
                    end else begin
                        phase <= phase - PHASE_W'(1);
                    end
                end
                ST_HOLD: begin
                    if (phase_done) begin
                        SRAM_CE <= 1'b1;
                        SRAM_UB <= 1'b1;
                        SRAM_LB <= 1'b1;
                        dq_en   <= 1'b0;
                        ready_q <= 1'b1;
                        phase   <= '0;
                        state   <= ST_IDLE;
                    end else begin
                        phase <= phase - PHASE_W'(1);
                    end
                end
            endcase
        end
    end

`ifdef SRAM_CTRL_STATS_EN
    // An access counts only once it completes HOLD, so aborted accesses are never tallied.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            wr_cnt <= '0;
            rd_cnt <= '0;
        end else if (state == ST_HOLD && phase_done) begin
            if (wr_q) begin
                wr_cnt <= wr_cnt + 32'd1;
            end else begin
                rd_cnt <= rd_cnt + 32'd1;
            end
        end
    end
`else
    assign wr_cnt = 32'd0;
    assign rd_cnt = 32'd0;
`endif
endmodule
